// File: rtl/serial_receiver.sv
// serial_receiver: reassembles SIZE-bit MSB-first chunks into 32-bit words,
// holds each word in a valid/ack output register, and flags output overrun
// and frames truncated by an idle timeout.
module serial_receiver #(
  parameter int SIZE    = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [SIZE-1:0] Din,
  input  logic            DinValid,
  input  logic            Clear,
  input  logic            DataAck,
  output logic [31:0]     DataOut,
  output logic            DataValid,
  output logic            RxBusy,
  output logic            Overrun,
  output logic            FrameErr
);

  if (!(SIZE == 1 || SIZE == 2 || SIZE == 4 || SIZE == 8 || SIZE == 16 || SIZE == 32)) begin : g_bad_size
    $error("serial_receiver: SIZE must be one of 1, 2, 4, 8, 16, 32");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  // Only the low 32-SIZE bits of the shift register ever reach the assembled
  // word, so the upper SIZE bits are not stored at all.
  localparam int SW = (SIZE >= 32) ? 1 : 32 - SIZE;
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [5:0]    STEP     = 6'(SIZE);
  localparam logic [5:0]    LAST_CNT = 6'(32 - SIZE);
  localparam logic [IW-1:0] TO_LAST  = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]    state;
  logic [SW-1:0] shreg;
  logic [5:0]    cnt;
  logic [IW-1:0] idle_cnt;
  logic [31:0]   word;
  logic          last;
  logic          load;
  logic          timeout;

  if (SIZE >= 32) begin : g_full
    assign word = Din;
  end else begin : g_shift
    assign word = {shreg, Din};
  end

  assign RxBusy = (state == RECV);

  // Completion, output-load and timeout qualifiers for the current edge
  always_comb begin
    last    = (cnt == LAST_CNT);
    load    = DinValid && last && (!DataValid || DataAck);
    timeout = (TIMEOUT != 0) && (state == RECV) && !DinValid && (idle_cnt == TO_LAST);
  end

  // Frame assembly: shift register, chunk counter, idle counter and FSM
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      idle_cnt <= '0;
    end else if (Clear) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      idle_cnt <= '0;
    end else if (DinValid) begin
      shreg    <= word[SW-1:0];
      idle_cnt <= '0;
      if (last) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt   <= cnt + STEP;
        state <= RECV;
      end
    end else if (timeout) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      idle_cnt <= '0;
    end else if (state == RECV) begin
      if (TIMEOUT != 0) idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // Output register with valid/ack handshake, overrun and frame-error flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
      FrameErr  <= 1'b0;
    end else if (Clear) begin
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      FrameErr <= timeout;
      if (DinValid && last && !load) Overrun <= 1'b1;
      if (load) begin
        DataOut   <= word;
        DataValid <= 1'b1;
      end else if (DataAck) begin
        DataValid <= 1'b0;
      end
    end
  end

endmodule
